beta_solver: RTL and testbench

- Downstream stage of the 3x3 matrix-inversion block in the least-squares regression path of the option-pricing engine.
- Consumes the inverted X^T X matrix one row per handshake beat, plus the X^T Y vector.
- Computes regression coefficients beta = inv(X^T X) * X^T Y with a single time-shared signed multiplier.
- Presents beta0..beta2 to the continuation-value evaluator.

---
 rtl/beta_solver.sv | 154 +++++++++++++++
 tb/tb_beta_solver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/beta_solver.sv
// Regression-coefficient stage: beta = inv(X^T X) * X^T Y using one time-shared signed multiplier.
// Define BETA_SAT_EN to clamp out-of-range betas and report them on ovf; otherwise betas wrap.
module beta_solver #(
  parameter int IN_W  = 32,
  parameter int Y_W   = 32,
  parameter int FRAC  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Y_W-1:0]   y0,
  input  logic [Y_W-1:0]   y1,
  input  logic [Y_W-1:0]   y2,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  inv0,
  input  logic [IN_W-1:0]  inv1,
  input  logic [IN_W-1:0]  inv2,
  output logic [OUT_W-1:0] beta0,
  output logic [OUT_W-1:0] beta1,
  output logic [OUT_W-1:0] beta2,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             ovf,
  output logic             busy
);
  localparam int PROD_W = IN_W + Y_W;
  localparam int ACC_W  = PROD_W + 2;

  // Handshakes: a row moves when in_valid && in_ready at a rising edge; betas are
  // consumed when o_valid && o_ready at a rising edge. Both valids are level signals.
  typedef enum logic [1:0] {IDLE, WAIT_ROW, MAC, DONE} state_t;
  state_t state, state_next;

  logic [1:0]              row_idx, mac_cnt;
  logic signed [Y_W-1:0]   y_r   [3];
  logic signed [IN_W-1:0]  row_r [3];
  logic [OUT_W-1:0]        beta_r [3];
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]        beta_val;

  assign prod     = row_r[mac_cnt] * y_r[mac_cnt];
  assign acc_next = acc + {{2{prod[PROD_W-1]}}, prod};

`ifdef BETA_SAT_EN
  localparam int HI_W = ACC_W - FRAC;
  logic [HI_W-1:0]      hi;
  logic [HI_W-OUT_W:0]  top;
  logic                 clip_hit;
  logic                 ovf_r;

  // Dropping the low FRAC bits is the floor shift; the result fits OUT_W only
  // when every bit from OUT_W-1 upward agrees with the sign.
  assign hi  = acc_next[ACC_W-1:FRAC];
  assign top = hi[HI_W-1:OUT_W-1];

  always_comb begin
    clip_hit = !((&top) || !(|top));
    if (!clip_hit)
      beta_val = hi[OUT_W-1:0];
    else if (top[HI_W-OUT_W])
      beta_val = {1'b1, {(OUT_W-1){1'b0}}};
    else
      beta_val = {1'b0, {(OUT_W-1){1'b1}}};
  end
  assign ovf = ovf_r;
`else
  assign beta_val = acc_next[FRAC +: OUT_W];
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    o_valid    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = WAIT_ROW;
      end
      WAIT_ROW: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        if (mac_cnt == 2'd2) state_next = (row_idx == 2'd2) ? DONE : WAIT_ROW;
      end
      DONE: begin
        o_valid = 1'b1;
        if (o_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_idx <= 2'd0;
      mac_cnt <= 2'd0;
      acc     <= '0;
      for (int i = 0; i < 3; i++) begin
        y_r[i]    <= '0;
        row_r[i]  <= '0;
        beta_r[i] <= '0;
      end
`ifdef BETA_SAT_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          y_r[0]  <= y0;
          y_r[1]  <= y1;
          y_r[2]  <= y2;
          row_idx <= 2'd0;
`ifdef BETA_SAT_EN
          ovf_r   <= 1'b0;
`endif
        end
        WAIT_ROW: if (in_valid) begin
          row_r[0] <= inv0;
          row_r[1] <= inv1;
          row_r[2] <= inv2;
          acc      <= '0;
          mac_cnt  <= 2'd0;
        end
        MAC: begin
          acc     <= acc_next;
          mac_cnt <= mac_cnt + 2'd1;
          if (mac_cnt == 2'd2) begin
            beta_r[row_idx] <= beta_val;
            row_idx         <= row_idx + 2'd1;
`ifdef BETA_SAT_EN
            ovf_r           <= ovf_r | clip_hit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign beta0 = beta_r[0];
  assign beta1 = beta_r[1];
  assign beta2 = beta_r[2];
endmodule

// File: tb/tb_beta_solver.sv
// Bench for beta_solver: directed vector table, reset abort sequence, then random solves
// checked against a plain-arithmetic model of beta = floor(inv * y / 2^16) reduced to 32 bits.
module tb_beta_solver;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, o_ready;
  logic [31:0] y0, y1, y2, inv0, inv1, inv2;
  logic        in_ready, o_valid, ovf, busy;
  logic [31:0] beta0, beta1, beta2;

  int checks = 0;
  int failures = 0;

  beta_solver dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y0(y0), .y1(y1), .y2(y2),
    .in_valid(in_valid), .in_ready(in_ready),
    .inv0(inv0), .inv1(inv1), .inv2(inv2),
    .beta0(beta0), .beta1(beta1), .beta2(beta2),
    .o_valid(o_valid), .o_ready(o_ready), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [0:8][31:0] inv;
    logic [0:2][31:0] y;
    logic [0:2][31:0] exp;
    logic             exp_ovf;
    int               stall;
    int               hold;
    bit               noise;
    bit               sid;
  } vec_t;

  localparam logic [0:8][31:0] ID = {32'h10000, 32'h0, 32'h0,
                                     32'h0, 32'h10000, 32'h0,
                                     32'h0, 32'h0, 32'h10000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [0:8][31:0] m, input logic [0:2][31:0] yv,
                                    output logic [0:2][31:0] b, output logic ov);
    logic signed [127:0] s, q;
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = '0;
      for (int j = 0; j < 3; j++) s = s + $signed(m[i*3+j]) * $signed(yv[j]);
      q = s >>> 16;
`ifdef BETA_SAT_EN
      if (q > 128'sd2147483647) begin
        b[i] = 32'h7FFFFFFF; ov = 1'b1;
      end else if (q < -128'sd2147483648) begin
        b[i] = 32'h80000000; ov = 1'b1;
      end else b[i] = q[31:0];
`else
      b[i] = q[31:0];
`endif
    end
  endfunction

  task automatic step(inout int lat);
    @(posedge clk); #1; lat++;
  endtask

  task automatic run_solve(input logic [0:8][31:0] m, input logic [0:2][31:0] yv,
                           input logic [0:2][31:0] eb, input logic eov,
                           input int stall, input int hold, input bit noise, input bit sid);
    int lat = 0;
    int guard;
    @(negedge clk);
    start = 1'b1; o_ready = (hold == 0);
    y0 = yv[0]; y1 = yv[1]; y2 = yv[2];
    step(lat);
    start = 1'b0;
    y0 = $urandom; y1 = $urandom; y2 = $urandom;
    check("busy_after_start", busy, 1);
    for (int r = 0; r < 3; r++) begin
      guard = 0;
      while (!in_ready && guard < 20) begin
        if (noise) begin
          in_valid = 1'b1; start = 1'b1;
          inv0 = $urandom; inv1 = $urandom; inv2 = $urandom;
        end
        step(lat); guard++;
      end
      check("row_ready", in_ready, 1);
      in_valid = 1'b0; start = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step(lat);
        check("stall_ready", in_ready, 1);
      end
      in_valid = 1'b1;
      inv0 = m[r*3]; inv1 = m[r*3+1]; inv2 = m[r*3+2];
      step(lat);
      in_valid = 1'b0;
      check("ready_low_in_mac", in_ready, 0);
    end
    guard = 0;
    while (!o_valid && guard < 20) begin
      step(lat); guard++;
    end
    check("o_valid", o_valid, 1);
    check("latency", 64'(lat), 64'(13 + 3 * stall));
    check("beta0", beta0, eb[0]);
    check("beta1", beta1, eb[1]);
    check("beta2", beta2, eb[2]);
    check("ovf", ovf, eov);
    for (int h = 0; h < hold; h++) begin
      start = sid;
      step(lat);
      check("hold_valid", o_valid, 1);
      check("hold_beta0", beta0, eb[0]);
      check("hold_beta2", beta2, eb[2]);
    end
    start = sid; o_ready = 1'b1;
    step(lat);
    start = 1'b0; o_ready = 1'b0;
    check("idle_valid", o_valid, 0);
    check("idle_busy", busy, 0);
    check("keep_beta1", beta1, eb[1]);
  endtask

  vec_t tbl[8];
  logic [0:8][31:0] rm;
  logic [0:2][31:0] ry, rb;
  logic rov;
  int lat_r;

  initial begin
    tbl[0] = '{inv: ID, y: {32'd3, 32'd5, 32'd7}, exp: {32'd3, 32'd5, 32'd7},
               exp_ovf: 0, stall: 0, hold: 0, noise: 0, sid: 0};
    tbl[1] = '{inv: {32'hFFFF8000, 32'h0, 32'h0, 32'h0, 32'h20000, 32'h0,
                     32'h10000, 32'h10000, 32'h10000},
               y: {32'd4, 32'hFFFFFFFA, 32'd10}, exp: {32'hFFFFFFFE, 32'hFFFFFFF4, 32'd8},
               exp_ovf: 0, stall: 0, hold: 0, noise: 1, sid: 0};
    tbl[2] = '{inv: ID, y: {32'd3, 32'd5, 32'd7}, exp: {32'd3, 32'd5, 32'd7},
               exp_ovf: 0, stall: 3, hold: 0, noise: 0, sid: 0};
    tbl[3] = '{inv: ID, y: {32'hFFFFFFFF, 32'd100, 32'd0}, exp: {32'hFFFFFFFF, 32'd100, 32'd0},
               exp_ovf: 0, stall: 0, hold: 5, noise: 0, sid: 1};
`ifdef BETA_SAT_EN
    tbl[4] = '{inv: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0},
               y: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, exp: {32'h7FFFFFFF, 32'h0, 32'h0},
               exp_ovf: 1, stall: 0, hold: 0, noise: 0, sid: 0};
    tbl[7] = '{inv: {32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0},
               y: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0}, exp: {32'h80000000, 32'h0, 32'h0},
               exp_ovf: 1, stall: 1, hold: 2, noise: 0, sid: 0};
`else
    tbl[4] = '{inv: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0},
               y: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, exp: {32'hFFFD0000, 32'h0, 32'h0},
               exp_ovf: 0, stall: 0, hold: 0, noise: 0, sid: 0};
    tbl[7] = '{inv: {32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0},
               y: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0}, exp: {32'h00010000, 32'h0, 32'h0},
               exp_ovf: 0, stall: 1, hold: 2, noise: 0, sid: 0};
`endif
    tbl[5] = '{inv: ID, y: {32'd9, 32'd8, 32'd1}, exp: {32'd9, 32'd8, 32'd1},
               exp_ovf: 0, stall: 0, hold: 0, noise: 0, sid: 0};
    tbl[6] = '{inv: {32'h00008000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00018000,
                     32'h0, 32'h0, 32'hFFFF0000},
               y: {32'hFFFFFFFD, 32'd0, 32'd1}, exp: {32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF},
               exp_ovf: 0, stall: 2, hold: 1, noise: 1, sid: 0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; o_ready = 1'b0;
    y0 = '0; y1 = '0; y2 = '0; inv0 = '0; inv1 = '0; inv2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_beta0", beta0, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_solve(tbl[i].inv, tbl[i].y, tbl[i].exp, tbl[i].exp_ovf,
                tbl[i].stall, tbl[i].hold, tbl[i].noise, tbl[i].sid);

    // Abort during the MAC of row 1: partial results must vanish.
    lat_r = 0;
    @(negedge clk);
    start = 1'b1; y0 = 32'd3; y1 = 32'd5; y2 = 32'd7; o_ready = 1'b1;
    step(lat_r);
    start = 1'b0;
    in_valid = 1'b1; inv0 = 32'h10000; inv1 = 32'h0; inv2 = 32'h0;
    step(lat_r);
    in_valid = 1'b0;
    for (int g = 0; g < 20 && !in_ready; g++) step(lat_r);
    in_valid = 1'b1; inv0 = 32'h0; inv1 = 32'h10000; inv2 = 32'h0;
    step(lat_r);
    in_valid = 1'b0;
    check("pre_abort_beta0", beta0, 3);
    check("pre_abort_valid", o_valid, 0);
    rst_n = 1'b0;
    step(lat_r);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_o_valid", o_valid, 0);
    check("abort_beta0", beta0, 0);
    check("abort_ovf", ovf, 0);
    rst_n = 1'b1;
    run_solve(ID, {32'd3, 32'd5, 32'd7}, {32'd3, 32'd5, 32'd7}, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 9; k++)
        rm[k] = (n % 3 == 0) ? $urandom : 32'($signed(int'($urandom_range(0, 262144)) - 131072));
      for (int k = 0; k < 3; k++)
        ry[k] = (n % 4 == 1) ? $urandom : 32'($signed(int'($urandom_range(0, 2000000)) - 1000000));
      ref_model(rm, ry, rb, rov);
      run_solve(rm, ry, rb, rov, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
